// File: rtl/td4_fetch.sv
// TD4 instruction fetch: 16x8 program store loaded word-by-word, then issued one instruction per cycle.
// Issue latency one cycle; load_ready is registered and high for all of LOAD, program words are dropped outside LOAD.
module td4_fetch #(
    parameter logic [3:0] RESET_PC = 4'h0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_en,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    output logic       load_ready,
    input  logic       run,
    input  logic       carry_i,
    output logic [3:0] opcode,
    output logic [3:0] immediate,
    output logic [3:0] pc,
    output logic       instr_valid,
    output logic       halted
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    localparam logic [3:0] OP_JNC = 4'b1110;
    localparam logic [3:0] OP_JMP = 4'b1111;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_mem [16];
    logic [3:0] r_fpc;
    logic [3:0] r_laddr;
    logic       r_load_ready;
    logic [3:0] r_opcode;
    logic [3:0] r_immediate;
    logic [3:0] r_pc;
    logic       r_instr_valid;
    logic       r_halted;

    logic       w_wr;
    logic       w_issue;
    logic [7:0] w_word;
    logic [3:0] w_fpc_nxt;
    logic       w_self_jmp;

    assign w_word     = r_mem[r_fpc];
    assign w_self_jmp = (w_word[7:4] == OP_JMP) && (w_word[3:0] == r_fpc);

    always_comb begin
        w_state_nxt = r_state;
        w_wr        = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (load_en) begin
                    w_state_nxt = S_LOAD;
                end else if (run) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_LOAD: begin
                w_wr = load_valid & r_load_ready;
                // The last entry ends the load so laddr never wraps onto word 0.
                if ((w_wr && (r_laddr == 4'hF)) || !load_en) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (run) begin
                    w_issue = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_fpc_nxt = r_fpc + 4'd1;
        if (w_word[7:4] == OP_JMP) begin
            w_fpc_nxt = w_word[3:0];
        end else if ((w_word[7:4] == OP_JNC) && !carry_i) begin
            w_fpc_nxt = w_word[3:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_fpc         <= RESET_PC;
            r_laddr       <= 4'h0;
            r_load_ready  <= 1'b0;
            r_opcode      <= 4'h0;
            r_immediate   <= 4'h0;
            r_pc          <= RESET_PC;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else begin
            r_state       <= w_state_nxt;
            r_load_ready  <= (w_state_nxt == S_LOAD);
            r_instr_valid <= w_issue;
            r_halted      <= w_issue && w_self_jmp;
            if (w_wr) begin
                r_mem[r_laddr] <= load_data;
                r_laddr        <= r_laddr + 4'd1;
            end else if ((r_state == S_IDLE) && load_en) begin
                r_laddr <= 4'h0;
            end
            if (w_issue) begin
                r_opcode    <= w_word[7:4];
                r_immediate <= w_word[3:0];
                r_pc        <= r_fpc;
                r_fpc       <= w_fpc_nxt;
            end
        end
    end

    assign load_ready  = r_load_ready;
    assign opcode      = r_opcode;
    assign immediate   = r_immediate;
    assign pc          = r_pc;
    assign instr_valid = r_instr_valid;
    assign halted      = r_halted;

endmodule

// File: doc/td4_fetch.md
TD4_FETCH -- requirements
Module: td4_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 4'h0: program counter value after reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port load_en  input  1  request program-load mode.
REQ-005 SHALL have port load_valid  input  1  load_data holds a valid program word.
REQ-006 SHALL have port load_data  input  8  program word: [7:4] opcode, [3:0] immediate.
REQ-007 SHALL have port load_ready  output  1  block accepts a program word this cycle.
REQ-008 SHALL have port run  input  1  request instruction issue.
REQ-009 SHALL have port carry_i  input  1  ALU carry flag from the CPU core.
REQ-010 SHALL have port opcode  output  4  issued opcode to the CPU core.
REQ-011 SHALL have port immediate  output  4  issued immediate to the CPU core.
REQ-012 SHALL have port pc  output  4  address of the instruction currently on opcode/immediate.
REQ-013 SHALL have port instr_valid  output  1  opcode/immediate hold an issued instruction this cycle.
REQ-014 SHALL have port halted  output  1  last issued instruction was JMP to its own address.

Function
REQ-015 SHALL contain a 16-entry x 8-bit program memory, written only in LOAD, read only in RUN.
REQ-016 SHALL implement FSM states IDLE, LOAD, RUN; internal fetch pointer fpc (4 bits) and load pointer laddr (4 bits).
REQ-017 IDLE: load_en=1 -> LOAD with laddr=0; else run=1 -> RUN; load_en wins when both are high.
REQ-018 LOAD: load_ready SHALL be 1 for the whole state, including the first LOAD cycle (registered; 0 in IDLE/RUN).
REQ-019 LOAD: on load_valid & load_ready, mem[laddr] <= load_data and laddr increments; no write occurs without load_valid.
REQ-020 LOAD: a write to laddr=15 SHALL return to IDLE next cycle, with load_ready 0 from that cycle; laddr SHALL NOT wrap within one load.
REQ-021 LOAD: load_en=0 -> IDLE next cycle; words already written are kept; unwritten entries keep prior contents.
REQ-022 RUN: each cycle, opcode <= mem[fpc][7:4], immediate <= mem[fpc][3:0], pc <= fpc, instr_valid <= 1 (one-cycle issue latency, one instruction per cycle).
REQ-023 RUN next-fpc: fetched opcode 4'b1111 (JMP) -> immediate; 4'b1110 (JNC) with carry_i=0 -> immediate; otherwise fpc+1, wrapping 15->0.
REQ-024 carry_i SHALL be sampled in the same cycle as the JNC fetch; no other opcode uses carry_i.
REQ-025 halted <= 1 when the fetched word is JMP with immediate == fpc; else 0; RUN continues issuing the same instruction.
REQ-026 RUN: run=0 -> IDLE next cycle; instr_valid 0 from that cycle; fpc held, so a later run=1 resumes at the held fpc.
REQ-027 load_en SHALL be ignored while in RUN.
REQ-028 Outside RUN, opcode/immediate/pc SHALL hold their last values; halted SHALL clear to 0.

Reset
REQ-029 rst_n=0 at a clock edge SHALL force IDLE, fpc=RESET_PC, laddr=0, pc=RESET_PC, opcode=0, immediate=0, instr_valid=0, load_ready=0, halted=0.
REQ-030 Reset SHALL clear all 16 memory entries to 8'h00.
REQ-031 Reset mid-LOAD or mid-RUN SHALL abort immediately; no write occurs in the reset cycle.

Verification
REQ-032 Load 16 words 8'h30..8'h3F with load_valid held high -> load_ready high for 16 cycles, then 0; mem[i]=8'h30+i.
REQ-033 Run after REQ-032 program -> instr_valid rises one cycle after RUN entry; opcode=3, immediate=0,1,..15, pc=0..15, then pc wraps to 0.
REQ-034 mem[2]=8'hF5 (JMP 5) -> pc sequence 0,1,2,5,6.
REQ-035 mem[1]=8'hE7 (JNC 7), carry_i=1 -> pc 0,1,2; repeat with carry_i=0 -> pc 0,1,7.
REQ-036 mem[4]=8'hF4 -> pc=4 repeats every cycle, halted=1; drop run -> halted=0, instr_valid=0.
REQ-037 rst_n=0 during LOAD after 3 words -> next cycle IDLE, load_ready=0, all memory entries 8'h00.
